serial_magnitude_comparator_controller: RTL and testbench

- Sequences the team's one-bit cascade comparator cell over two WIDTH-bit operands, MSB first, one bit per clock.
- Feeds the cell's greater/equal outputs back as its cascade inputs, and reports greater/equal/less after the last bit.
- Provides an area-cheap alternative to a parallel magnitude comparator, with a start/done handshake to the surrounding datapath.

---
 rtl/serial_magnitude_comparator_controller_pkg.sv | 16 +
 rtl/serial_magnitude_comparator_controller_if.sv | 28 ++
 rtl/serial_magnitude_comparator_controller_cell.sv | 15 +
 rtl/serial_magnitude_comparator_controller.sv | 122 ++++++++++++
 tb/tb_serial_magnitude_comparator_controller.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/serial_magnitude_comparator_controller_pkg.sv
// Shared types for the serial magnitude comparator controller.
// Controller FSM state encoding and the index-register width helper.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index register width: clog2 of the operand width, never below one bit.
  function automatic int idx_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_controller_if.sv
// Start/done bundle between the datapath (master) and the serial comparator (slave).
// Handshake: start is sampled only while idle; done is a one-cycle pulse, results hold until the next accept.
interface serial_magnitude_comparator_controller_if #(
  parameter int WIDTH = 8
);
  import serial_comparator_pkg::*;

  logic             start;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             greater;
  logic             equal;
  logic             less;
  state_t           fsm_state;

  modport master (
    output start, operand_a, operand_b,
    input  busy, done, greater, equal, less, fsm_state
  );

  modport slave (
    input  start, operand_a, operand_b,
    output busy, done, greater, equal, less, fsm_state
  );

endinterface

// File: rtl/serial_magnitude_comparator_controller_cell.sv
// One-bit cascade comparator cell: resolves one bit pair, passing the upstream
// decision through once the higher bits have already differed.
module one_bit_comparator (
  input  logic input_greater_than,
  input  logic input_equal,
  input  logic x,
  input  logic y,
  output logic output_greater_than,
  output logic output_equal
);

  assign output_greater_than = input_equal ? (x & ~y)  : input_greater_than;
  assign output_equal        = input_equal ? (x ~^ y)  : input_equal;

endmodule

// File: rtl/serial_magnitude_comparator_controller.sv
// Bit-serial magnitude comparator: walks both operands MSB first through one cascade cell.
// Define SERIAL_COMPARATOR_EARLY_EXIT_EN to finish as soon as the operands are known to differ.
module serial_magnitude_comparator_controller
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  serial_magnitude_comparator_controller_if.slave bus
);

  localparam int IW = idx_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             gt_r;
  logic             eq_r;
  logic [IW-1:0]    idx;
  logic             busy_r;
  logic             done_r;
  logic             greater_r;
  logic             equal_r;
  logic             less_r;

  logic x_bit;
  logic y_bit;
  logic gt_nxt;
  logic eq_nxt;
  logic finish;

  generate
    if (WIDTH == 1) begin : g_single
      assign x_bit = a_r[0];
      assign y_bit = b_r[0];
    end else begin : g_multi
      assign x_bit = a_r[idx];
      assign y_bit = b_r[idx];
    end
  endgenerate

  one_bit_comparator u_cell (
    .input_greater_than  (gt_r),
    .input_equal         (eq_r),
    .x                   (x_bit),
    .y                   (y_bit),
    .output_greater_than (gt_nxt),
    .output_equal        (eq_nxt)
  );

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  assign finish = (idx == '0) || !eq_nxt;
`else
  assign finish = (idx == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      gt_r      <= 1'b0;
      eq_r      <= 1'b1;
      idx       <= IW'(WIDTH - 1);
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      greater_r <= 1'b0;
      equal_r   <= 1'b0;
      less_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r       <= bus.operand_a;
            b_r       <= bus.operand_b;
            gt_r      <= 1'b0;
            eq_r      <= 1'b1;
            idx       <= IW'(WIDTH - 1);
            busy_r    <= 1'b1;
            greater_r <= 1'b0;
            equal_r   <= 1'b0;
            less_r    <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          gt_r <= gt_nxt;
          eq_r <= eq_nxt;
          if (finish) begin
            // Results come from the cell outputs of this edge, which include the last bit.
            greater_r <= gt_nxt;
            equal_r   <= eq_nxt;
            less_r    <= ~gt_nxt & ~eq_nxt;
            done_r    <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.greater   = greater_r;
  assign bus.equal     = equal_r;
  assign bus.less      = less_r;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_serial_magnitude_comparator_controller.sv
// Directed bench for the serial comparator: WIDTH=8 and WIDTH=1 instances,
// vector tables plus start-held and mid-run reset sequences.
module tb_serial_magnitude_comparator_controller;
  import serial_comparator_pkg::*;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] res;
    int         lat;
    int         lat_ee;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_magnitude_comparator_controller_if #(.WIDTH(8)) if8 ();
  serial_magnitude_comparator_controller_if #(.WIDTH(1)) if1 ();

  serial_magnitude_comparator_controller #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  serial_magnitude_comparator_controller #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];
  vec_t v8[8];
  vec_t v1[4];

  bit sel = 1'b0;
  wire       s_done  = sel ? if1.done : if8.done;
  wire       s_busy  = sel ? if1.busy : if8.busy;
  wire [2:0] s_res   = sel ? {if1.greater, if1.equal, if1.less}
                           : {if8.greater, if8.equal, if8.less};
  wire [1:0] s_state = sel ? if1.fsm_state : if8.fsm_state;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick_lat(input vec_t v);
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    return v.lat_ee;
`else
    return v.lat;
`endif
  endfunction

  // Latency counts the accept edge as 1 and each following edge up to the one raising done.
  task automatic run_cmp(input bit w1, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] res, input int lat);
    int  cnt;
    bit  seen;
    sel = w1;
    @(negedge clk);
    if (w1) begin
      if1.start = 1'b1; if1.operand_a = a[0]; if1.operand_b = b[0];
    end else begin
      if8.start = 1'b1; if8.operand_a = a;    if8.operand_b = b;
    end
    exp_q.push_back(res);
    @(posedge clk); #1;
    if1.start = 1'b0;
    if8.start = 1'b0;
    check("accept_clear", s_res, 3'b000);
    check("accept_busy", s_busy, 1);
    cnt  = 1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (s_done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("latency", cnt, lat);
    if (exp_q.size() > 0) check("result", s_res, exp_q.pop_front());
    @(posedge clk); #1;
    check("done_pulse", s_done, 0);
    check("result_hold", s_res, res);
    check("idle_busy", s_busy, 0);
  endtask

  initial begin
    int t_done[3];
    int nd;
    int low_cnt;
    logic [2:0] r_run[3];
    bit bad_done;

    v8[0] = '{8'hA5, 8'hA5, EQ, 9, 9};
    v8[1] = '{8'h80, 8'h7F, GT, 9, 2};
    v8[2] = '{8'h10, 8'h11, LT, 9, 9};
    v8[3] = '{8'hFF, 8'h00, GT, 9, 2};
    v8[4] = '{8'h00, 8'hFF, LT, 9, 2};
    v8[5] = '{8'h5A, 8'h4A, GT, 9, 5};
    v8[6] = '{8'h00, 8'h00, EQ, 9, 9};
    v8[7] = '{8'h7E, 8'h7F, LT, 9, 9};
    v1[0] = '{8'h01, 8'h00, GT, 2, 2};
    v1[1] = '{8'h00, 8'h01, LT, 2, 2};
    v1[2] = '{8'h01, 8'h01, EQ, 2, 2};
    v1[3] = '{8'h00, 8'h00, EQ, 2, 2};

    if8.start = 1'b0; if8.operand_a = '0; if8.operand_b = '0;
    if1.start = 1'b0; if1.operand_a = '0; if1.operand_b = '0;
    rst_n = 1'b0;
    #1;
    check("reset_state", if8.fsm_state, IDLE);
    check("reset_outs", {if8.busy, if8.done, if8.greater, if8.equal, if8.less}, 5'b0);
    check("reset_outs_w1", {if1.busy, if1.done, if1.greater, if1.equal, if1.less}, 5'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_cmp(1'b0, v8[i].a, v8[i].b, v8[i].res, pick_lat(v8[i]));
    for (int i = 0; i < 4; i++) run_cmp(1'b1, v1[i].a, v1[i].b, v1[i].res, pick_lat(v1[i]));

    // start held high: three back-to-back runs, operands changed mid-run.
    sel = 1'b0;
    @(negedge clk);
    if8.start = 1'b1; if8.operand_a = 8'h33; if8.operand_b = 8'h33;
    nd = 0;
    low_cnt = 0;
    for (int e = 0; e < 60 && nd < 3; e++) begin
      @(posedge clk); #1;
      if (e == 3) begin
        if8.operand_a = 8'h33; if8.operand_b = 8'h32;
      end
      if (if8.done) begin
        t_done[nd] = e;
        r_run[nd]  = {if8.greater, if8.equal, if8.less};
        nd++;
        if (nd == 3) if8.start = 1'b0;
      end else if (nd >= 1 && !if8.busy) begin
        low_cnt++;
      end
    end
    if8.start = 1'b0;
    check("held_runs", nd, 3);
    if (nd == 3) begin
      check("held_period1", t_done[1] - t_done[0], 10);
      check("held_period2", t_done[2] - t_done[1], 10);
      check("held_res1", r_run[0], EQ);
      check("held_res2", r_run[1], GT);
      check("held_res3", r_run[2], GT);
    end
    check("held_busy_low", low_cnt, 2);
    repeat (2) @(posedge clk);

    // Reset in the third RUN cycle aborts without a done.
    @(negedge clk);
    if8.start = 1'b1; if8.operand_a = 8'hF0; if8.operand_b = 8'h0F;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {if8.busy, if8.done, if8.greater, if8.equal, if8.less}, 5'b0);
    check("rst_mid_state", if8.fsm_state, IDLE);
    bad_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (if8.done) bad_done = 1'b1;
    end
    check("rst_no_done", bad_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_after_state", s_state, 2'd0);
    check("rst_after_done", s_done, 0);
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    run_cmp(1'b0, 8'h01, 8'h02, LT, 8);
`else
    run_cmp(1'b0, 8'h01, 8'h02, LT, 9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
